regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port integer register file with built-in write-back scoreboard for the
//  pipelined RISC-V core. Replaces the 2R/1W regfile: N read ports, M write ports, write-first
//  bypass, x0 hardwired to zero, per-register pending-write counters. Sits between decode (read,
//  issue) and write-back; decode uses rbusy/issue_ready to generate stalls.
// PARAMETERS
//  XLEN   32  data width
//  NREGS  32  number of architectural registers (power of 2); AW = $clog2(NREGS)
//  NRD    2   read ports
//  NWR    1   write ports (1..4)
//  PCW    2   pending-counter width; max in-flight writes per register = 2**PCW-1
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  raddr        in   NRD*AW     read addresses
//  rdata        out  NRD*XLEN   read data (combinational)
//  rbusy        out  NRD        register at raddr still has a write outstanding
//  we           in   NWR        write enables (write-back)
//  waddr        in   NWR*AW     write addresses
//  wdata        in   NWR*XLEN   write data
//  issue_valid  in   1          decode issues an instruction that will write issue_rd
//  issue_rd     in   AW         destination of issued instruction
//  issue_ready  out  1          issue accepted this cycle
//  err_underflow out 1          sticky: write to register with zero pending count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all counters 0, err_underflow 0. Release is sync to clk.
//  - Read: rdata[i] = 0 if raddr[i]==0; else highest-index write port with we & waddr==raddr[i]
//    supplies wdata (same-cycle bypass); else stored value. Zero-cycle latency.
//  - Write: at posedge, each we port with waddr!=0 updates the array; same address on several ports
//    -> highest port index wins. Writes to x0 ignored (no counter effect, no error).
//  - Pending counter cnt[r]: next = cnt - hits(r) + (issue accepted & issue_rd==r), hits(r) = number
//    of write ports with we & waddr==r. Never underflows: if hits > cnt, clamp to 0 (+issue) and
//    set err_underflow (stays 1 until reset).
//  - rbusy[i] = (raddr[i]!=0) & ((cnt[raddr[i]] - hits(raddr[i])) > 0); i.e. a write-back landing
//    this cycle clears the hazard via bypass; a same-cycle issue does not affect rbusy.
//  - issue_ready = (issue_rd==0) | (cnt[issue_rd] - hits(issue_rd) < 2**PCW-1). Issue accepted =
//    issue_valid & issue_ready. issue_rd==0 accepted always, no counter change.
//  - Simultaneous issue and final write-back on same reg: count stays 1 (new producer pending).
//  - issue_valid without issue_ready: no state change; decode must hold and retry.
//  - Reset asserted mid-operation discards all pending counts and data immediately.
// STRUCTURE
//  - Package regfile_pkg: XLEN, NREGS defaults, AW localparam, typedef logic [XLEN-1:0] word_t,
//    typedef logic [AW-1:0] reg_idx_t.
//  - Sub-module rf_pend_cnt (one per register r=1..NREGS-1): PCW counter with hits/issue inputs,
//    busy, full and underflow outputs. Data array and bypass muxes in top level.
// TESTING
//  1 Reset: rst_n=0 mid-run after writes -> all rdata 0, rbusy 0, issue_ready 1, err 0.
//  2 Write x5=A5A5A5A5, next cycle raddr[0]=5 -> rdata[0]=A5A5A5A5; same-cycle read -> bypassed.
//  3 Write x0=FFFFFFFF, raddr=0 -> rdata=0, no err; NWR=2 both write x7 (11,22) -> x7=22.
//  4 Issue x3 three times (PCW=2) -> issue_ready=0 on 4th, rbusy for x3=1; 3 writes clear it,
//    rbusy drops in the cycle of the 3rd write with rdata = 3rd wdata.
//  5 Issue x9 and write x9 same cycle with cnt=1 -> cnt stays 1, rbusy stays 1 next cycle.
//  6 Write x4 with cnt=0 -> data stored, err_underflow=1 and stays 1 until rst_n low.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file with write-back scoreboard.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_idx_t;

endpackage

// File: rtl/rf_pend_cnt.sv
// Pending-write counter for one architectural register.
// The count is the number of issued producers whose write-back has not landed yet.
// Write-backs landing this cycle (hits) are removed before busy/full are judged,
// so a landing write clears the hazard in the same cycle through the bypass.
module rf_pend_cnt #(
  parameter int PCW = 2,
  parameter int HW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [HW-1:0] hits,
  input  logic          issue,
  output logic          busy,
  output logic          full,
  output logic          underflow
);

  localparam int CMAX = (1 << PCW) - 1;

  logic [PCW-1:0] cnt_q;
  logic [PCW-1:0] rem;
  logic [PCW-1:0] cnt_d;

  // Remaining count after this cycle's write-backs; clamp at zero on underflow.
  always_comb begin
    underflow = 1'b0;
    rem       = '0;
    cnt_d     = '0;
    if (int'(hits) > int'(cnt_q)) begin
      underflow = 1'b1;
      rem       = '0;
    end else begin
      rem = cnt_q - PCW'(hits);
    end
    busy  = (rem != '0);
    full  = (rem == PCW'(CMAX));
    cnt_d = rem;
    if (issue && !full) begin
      cnt_d = rem + PCW'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-first bypass, x0 hardwired to zero,
// and per-register pending-write counters used by decode to stall on hazards.
//
// Issue handshake: decode holds issue_valid/issue_rd until issue_ready is seen
// high in the same cycle; the issue is accepted exactly when issue_valid &
// issue_ready at the rising edge. When not accepted, nothing changes and decode
// retries with the same destination. issue_rd == 0 is always accepted and has no
// counter effect.
module regfile_sb #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int PCW   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0] raddr,
  output logic [NRD*XLEN-1:0]         rdata,
  output logic [NRD-1:0]              rbusy,
  input  logic [NWR-1:0]              we,
  input  logic [NWR*$clog2(NREGS)-1:0] waddr,
  input  logic [NWR*XLEN-1:0]         wdata,
  input  logic                        issue_valid,
  input  logic [$clog2(NREGS)-1:0]    issue_rd,
  output logic                        issue_ready,
  output logic                        err_underflow
);

  localparam int AW = $clog2(NREGS);
  localparam int HW = $clog2(NWR + 1);

  logic [XLEN-1:0]  mem [NREGS];
  logic [HW-1:0]    hits [NREGS];
  logic [NREGS-1:0] busy_v;
  logic [NREGS-1:0] full_v;
  logic [NREGS-1:0] unf_v;
  logic             issue_acc;
  logic             err_q;

  // Count, per register, how many write ports land on it this cycle (x0 excluded).
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      hits[r] = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && (waddr[p*AW +: AW] != '0)) begin
        hits[waddr[p*AW +: AW]] = hits[waddr[p*AW +: AW]] + HW'(1);
      end
    end
  end

  // One pending counter per real register; x0 is never busy or full.
  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign busy_v[r] = 1'b0;
      assign full_v[r] = 1'b0;
      assign unf_v[r]  = 1'b0;
    end else begin : g_reg
      rf_pend_cnt #(
        .PCW (PCW),
        .HW  (HW)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .hits      (hits[r]),
        .issue     (issue_acc && (issue_rd == AW'(r))),
        .busy      (busy_v[r]),
        .full      (full_v[r]),
        .underflow (unf_v[r])
      );
    end
  end

  assign issue_ready   = (issue_rd == '0) || !full_v[issue_rd];
  assign issue_acc     = issue_valid && issue_ready;
  assign err_underflow = err_q;

  // Read ports: x0 reads zero, else highest-index matching write port bypasses, else array.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    always_comb begin
      rdata[i*XLEN +: XLEN] = mem[raddr[i*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (waddr[p*AW +: AW] == raddr[i*AW +: AW])) begin
          rdata[i*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
        end
      end
      if (raddr[i*AW +: AW] == '0) begin
        rdata[i*XLEN +: XLEN] = '0;
      end
    end
    assign rbusy[i] = busy_v[raddr[i*AW +: AW]];
  end

  // Register array update; later ports override earlier ones on the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (waddr[p*AW +: AW] != '0)) begin
          mem[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || (|unf_v);
    end
  end

endmodule
